// File: rtl/operand_fetch.sv
// operand_fetch: issue stage that reads two source operands from the register
// file, tracks outstanding destination writes in a busy scoreboard, stalls on
// RAW/WAW hazards and forwards a write-back that lands on the accept edge.
// Timeline per instruction: accept edge -> READ (register file data valid)
// -> VALID (operands presented until the consumer takes them).
module operand_fetch #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // instruction side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic              in_wr,
  // register file read ports (one-cycle read latency)
  output logic [4:0]        rf_a_reg,
  output logic [4:0]        rf_b_reg,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  // write-back snoop, same signals that write the register file
  input  logic              wb_en,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  // consumer side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [4:0]        out_rd,
  output logic              out_wr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0] busy;
  logic [31:0] busy_clr;
  logic [31:0] busy_nxt;
  logic        hazard;
  logic        accept;
  logic        ld_out;

  // fields captured at accept, consumed in READ
  logic [4:0]        rs_p0;
  logic [4:0]        rt_p0;
  logic [4:0]        rd_p0;
  logic              wr_p0;
  logic              fwd_a_p0;
  logic              fwd_b_p0;
  logic [DATA_W-1:0] fwd_a_data_p0;
  logic [DATA_W-1:0] fwd_b_data_p0;

  // Operand select: r0 always reads as zero; a write-back captured on the
  // accept edge overrides the register file, which returned the pre-write value.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [4:0]        idx,
    input logic              fwd,
    input logic [DATA_W-1:0] fwd_data,
    input logic [DATA_W-1:0] rf_data
  );
    if (idx == 5'd0)
      return '0;
    else if (fwd)
      return fwd_data;
    else
      return rf_data;
  endfunction

  // Register file is addressed straight from the instruction fields so the
  // data is ready one cycle after the accept edge.
  assign rf_a_reg  = in_rs;
  assign rf_b_reg  = in_rt;
  assign out_valid = (state == VALID);

  // Scoreboard as seen this cycle: a write-back retires its register before
  // the hazard check, so an instruction can issue on the write-back cycle.
  always_comb begin
    busy_clr = busy;
    if (wb_en)
      busy_clr[wb_reg] = 1'b0;
  end

  assign hazard = busy_clr[in_rs] | busy_clr[in_rt] | (in_wr & busy_clr[in_rd]);

  // Next-state, handshake and output-load decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ld_out    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~hazard;
      end
      READ: begin
        ld_out    = 1'b1;
        state_nxt = VALID;
      end
      VALID: begin
        in_ready = out_ready & ~hazard;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    accept = in_valid & in_ready;
    if (accept)
      state_nxt = READ;
  end

  // Scoreboard update: a new destination set overrides a same-cycle clear.
  always_comb begin
    busy_nxt = busy_clr;
    if (accept && in_wr && (in_rd != 5'd0))
      busy_nxt[in_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  // ---- stage p0: accept edge, capture fields and forward flags ----
  // Forward flags: set when the write-back lands on the same edge as accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_p0 <= 1'b0;
      fwd_b_p0 <= 1'b0;
    end else if (accept) begin
      fwd_a_p0 <= wb_en && (wb_reg == in_rs) && (wb_reg != 5'd0);
      fwd_b_p0 <= wb_en && (wb_reg == in_rt) && (wb_reg != 5'd0);
    end
  end

  // Captured instruction fields and forwarded data (no reset needed).
  always_ff @(posedge clk) begin
    if (accept) begin
      rs_p0         <= in_rs;
      rt_p0         <= in_rt;
      rd_p0         <= in_rd;
      wr_p0         <= in_wr;
      fwd_a_data_p0 <= wb_data;
      fwd_b_data_p0 <= wb_data;
    end
  end

  // ---- stage p1: READ edge, operands loaded and held through VALID ----
  // Output registers load only in READ, so they stay stable under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_a  <= '0;
      out_b  <= '0;
      out_rd <= '0;
      out_wr <= 1'b0;
    end else if (ld_out) begin
      out_a  <= pick_operand(rs_p0, fwd_a_p0, fwd_a_data_p0, rf_a);
      out_b  <= pick_operand(rt_p0, fwd_b_p0, fwd_b_data_p0, rf_b);
      out_rd <= rd_p0;
      out_wr <= wr_p0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a one-cycle-latency register file model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_wr;
  logic [4:0]  rf_a_reg, rf_b_reg;
  logic [31:0] rf_a, rf_b;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic [4:0]  out_rd;
  logic        out_wr;

  logic [31:0] rf_mem [32];

  int n_vec = 0;
  int n_err = 0;

  operand_fetch #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_wr     (in_wr),
    .rf_a_reg  (rf_a_reg),
    .rf_b_reg  (rf_b_reg),
    .rf_a      (rf_a),
    .rf_b      (rf_b),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_rd    (out_rd),
    .out_wr    (out_wr)
  );

  always #5 clk = ~clk;

  // Register file: data one cycle after address, pre-write value on same-edge write.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
      rf_a <= '0;
      rf_b <= '0;
    end else begin
      rf_a <= rf_mem[rf_a_reg];
      rf_b <= rf_mem[rf_b_reg];
      if (wb_en) rf_mem[wb_reg] <= wb_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic present(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic wr);
    in_valid = 1'b1;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_wr    = wr;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0; in_wr = 1'b0;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0; out_ready = 1'b0;

    // reset state
    tick; tick;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_a",     out_a,          32'd0);
    chk("rst_out_rd",    32'(out_rd),    32'd0);
    chk("rst_busy",      dut.busy,       32'd0);
    rst = 1'b0;
    settle;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // preload r3=5, r4=7 through write-back (not busy: ignored by scoreboard)
    wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'd5;
    tick;
    wb_reg = 5'd4; wb_data = 32'd7;
    tick;
    wb_en = 1'b0;

    // basic fetch
    present(5'd3, 5'd4, 5'd5, 1'b1);
    settle;
    chk("basic_in_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    settle;
    chk("basic_read_out_valid", 32'(out_valid), 32'd0);
    chk("basic_busy5",          dut.busy,       32'h0000_0020);
    tick;
    chk("basic_out_valid", 32'(out_valid), 32'd1);
    chk("basic_out_a",     out_a,          32'd5);
    chk("basic_out_b",     out_b,          32'd7);
    chk("basic_out_rd",    32'(out_rd),    32'd5);
    chk("basic_out_wr",    32'(out_wr),    32'd1);

    // RAW stall on r5, released and forwarded by write-back
    out_ready = 1'b1;
    present(5'd5, 5'd4, 5'd7, 1'b0);
    settle;
    chk("raw_stall_valid", 32'(in_ready), 32'd0);
    tick;
    settle;
    chk("raw_idle_out_valid", 32'(out_valid), 32'd0);
    chk("raw_stall_idle",     32'(in_ready),  32'd0);
    wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'h1234;
    settle;
    chk("raw_release", 32'(in_ready), 32'd1);
    tick;
    wb_en = 1'b0; in_valid = 1'b0;
    settle;
    chk("raw_busy_clear", dut.busy, 32'd0);
    tick;
    chk("raw_out_valid", 32'(out_valid), 32'd1);
    chk("raw_fwd_a",     out_a,          32'h1234);
    chk("raw_out_b",     out_b,          32'd7);
    chk("raw_out_rd",    32'(out_rd),    32'd7);
    chk("raw_out_wr",    32'(out_wr),    32'd0);

    // register zero: r0 written to 0xFFFF in the file but always reads 0
    wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'h0000_FFFF;
    tick;
    wb_en = 1'b0;
    present(5'd0, 5'd0, 5'd0, 1'b1);
    settle;
    chk("r0_in_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    settle;
    chk("r0_busy", dut.busy, 32'd0);
    tick;
    chk("r0_out_valid", 32'(out_valid), 32'd1);
    chk("r0_out_a",     out_a,          32'd0);
    chk("r0_out_b",     out_b,          32'd0);
    chk("r0_out_wr",    32'(out_wr),    32'd1);

    // back-pressure
    tick;
    out_ready = 1'b0;
    present(5'd3, 5'd4, 5'd8, 1'b1);
    settle;
    chk("bp_in_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    tick;
    present(5'd4, 5'd3, 5'd9, 1'b1);
    for (int i = 0; i < 5; i++) begin
      settle;
      chk("bp_hold_in_ready",  32'(in_ready),  32'd0);
      chk("bp_hold_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_out_a",     out_a,          32'd5);
      chk("bp_hold_out_b",     out_b,          32'd7);
      chk("bp_hold_out_rd",    32'(out_rd),    32'd8);
      tick;
    end
    out_ready = 1'b1;
    settle;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0; out_ready = 1'b0;
    settle;
    chk("bp_read_out_valid", 32'(out_valid), 32'd0);
    chk("bp_busy",           dut.busy,       32'h0000_0300);
    tick;
    chk("bp_next_out_valid", 32'(out_valid), 32'd1);
    chk("bp_next_out_a",     out_a,          32'd7);
    chk("bp_next_out_b",     out_b,          32'd5);
    chk("bp_next_out_rd",    32'(out_rd),    32'd9);

    // WAW stall on r6 and set-wins
    out_ready = 1'b1;
    present(5'd1, 5'd2, 5'd6, 1'b1);
    settle;
    chk("waw_first_in_ready", 32'(in_ready), 32'd1);
    tick;
    settle;
    chk("waw_read_in_ready", 32'(in_ready), 32'd0);
    chk("waw_busy6",         dut.busy,      32'h0000_0340);
    tick;
    settle;
    chk("waw_valid_out_valid", 32'(out_valid), 32'd1);
    chk("waw_stall_valid",     32'(in_ready),  32'd0);
    tick;
    settle;
    chk("waw_stall_idle", 32'(in_ready), 32'd0);
    wb_en = 1'b1; wb_reg = 5'd6; wb_data = 32'h66;
    settle;
    chk("waw_release", 32'(in_ready), 32'd1);
    tick;
    wb_en = 1'b0; in_valid = 1'b0;
    settle;
    chk("waw_set_wins", dut.busy, 32'h0000_0340);
    tick;
    chk("waw_out_valid", 32'(out_valid), 32'd1);
    chk("waw_out_rd",    32'(out_rd),    32'd6);

    // mid-operation reset while in READ with busy[9] set
    present(5'd3, 5'd4, 5'd10, 1'b1);
    settle;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    settle;
    chk("mrst_busy_before", dut.busy, 32'h0000_0740);
    rst = 1'b1;
    settle;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy",      dut.busy,       32'd0);
    chk("mrst_out_a",     out_a,          32'd0);
    chk("mrst_out_rd",    32'(out_rd),    32'd0);
    tick; tick;
    rst = 1'b0;
    settle;
    chk("mrst_post_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("mrst_no_output", 32'(out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have ports clk, rst, with clk listed first: clk input 1, rising-edge clock; rst input 1, reset, asynchronous, active-high.
REQ-002 SHALL have the instruction-side ports: in_valid input 1; in_ready output 1; in_rs input 5; in_rt input 5; in_rd input 5; in_wr input 1 (instruction writes in_rd).
REQ-003 SHALL have the register-file read ports: rf_a_reg output 5; rf_b_reg output 5; rf_a input 32; rf_b input 32. The register file returns data one cycle after it samples the address, and returns the pre-write value on a same-edge write.
REQ-004 SHALL have the write-back snoop ports, the same signals that drive the register file: wb_en input 1; wb_reg input 5; wb_data input 32.
REQ-005 SHALL have the consumer-side ports: out_valid output 1; out_ready input 1; out_a output 32; out_b output 32; out_rd output 5; out_wr output 1.

Function
REQ-006 SHALL implement an FSM with states IDLE, READ and VALID.
REQ-007 SHALL drive in_ready = 1 when the state is IDLE, or when the state is VALID and out_ready is 1, and only when there is no hazard (REQ-010). in_ready SHALL be combinational.
REQ-008 SHALL drive rf_a_reg = in_rs and rf_b_reg = in_rt combinationally at all times.
REQ-009 SHALL perform an accept (in_valid & in_ready) as follows: capture in_rs, in_rt, in_rd and in_wr; the next state SHALL be READ.
REQ-010 SHALL keep a 32-bit busy scoreboard, with bit 0 hardwired to 0. A hazard exists if busy'[in_rs], busy'[in_rt] or (in_wr & busy'[in_rd]) is set. busy' is busy with bit wb_reg cleared when wb_en is 1.
REQ-011 SHALL update the scoreboard at each edge:
- wb_en clears busy[wb_reg].
- An accept with in_wr=1 and in_rd≠0 sets busy[in_rd].
- If both hit the same register in one cycle, set wins.
REQ-012 SHALL ignore wb_en to a register that is not busy for scoreboard purposes.
REQ-013 SHALL handle a same-cycle write-back at accept: if wb_en is 1 and wb_reg equals in_rs (or in_rt) and is nonzero, latch wb_data into a per-port forward register and set a per-port forward flag.
REQ-014 SHALL, in READ, load out_a with 0 if rs=0, else the forwarded data if the forward flag is set, else rf_a. out_b SHALL be loaded likewise from rt and rf_b. out_rd and out_wr SHALL be loaded from the captured fields. The next state SHALL be VALID.
REQ-015 SHALL hold out_valid = 1 exactly in VALID, and hold out_a, out_b, out_rd and out_wr stable while out_valid=1 and out_ready=0.
REQ-016 SHALL leave VALID on out_ready=1: to READ if an accept occurs in the same cycle, else to IDLE.
REQ-017 SHALL give a latency of 2 cycles from accept to out_valid, and a peak throughput of one instruction per 2 cycles.
REQ-018 SHALL ignore in_valid outside an accept, and SHALL never drop or duplicate an instruction.

Reset
REQ-019 SHALL, while rst=1, force the following immediately, independent of clk: state IDLE; busy all 0; forward flags 0; out_valid 0; out_a 0; out_b 0; out_rd 0; out_wr 0.
REQ-020 SHALL discard any instruction in flight when reset is asserted mid-operation, with no output produced for it.
REQ-021 SHALL make in_ready 1 in the first cycle after rst deasserts, given no hazard.

Verification
REQ-022 SHALL cover basic fetch: r3=5 and r4=7 are preloaded; accept rs=3, rt=4, rd=5, wr=1 -> out_valid 2 cycles later with out_a=5, out_b=7, out_rd=5, out_wr=1; busy[5]=1.
REQ-023 SHALL cover the RAW stall: after REQ-022, present rs=5 -> in_ready=0 until wb_en=1, wb_reg=5, wb_data=0x1234. That same cycle SHALL accept, and out_a SHALL equal 0x1234 via forwarding.
REQ-024 SHALL cover register zero: with rs=0, rt=0 and r0 written to 0xFFFF by write-back -> out_a=0, out_b=0, and busy is never set for rd=0.
REQ-025 SHALL cover back-pressure: out_ready is held 0 for 5 cycles in VALID -> outputs are held constant and in_ready=0. Then out_ready=1 with in_valid=1 -> accept in the same cycle, and the next out_valid follows 2 cycles later.
REQ-026 SHALL cover the WAW stall and set-wins: an instruction with rd=6 is outstanding; present another with rd=6 -> stall until wb to r6, accept in that cycle, and busy[6] remains 1.
REQ-027 SHALL cover mid-operation reset: assert rst while in READ with busy[9]=1 -> out_valid=0, busy=0, and no output for the discarded instruction after rst deasserts.
